alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter OPERAND_WIDTH, default 16, operand/result width; SHALL be a power of two, 8 to 64.
REQ-002 Parameter NUM_OPERATIONS, default 4, opcode width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operation presented.
REQ-006 in_ready  output  1  block accepts the operation on this edge.
REQ-007 InA, InB  input  OPERAND_WIDTH  operands.
REQ-008 Cin, invA, invB, sign  input  1 each  carry-in, invert A, invert B, signed mode.
REQ-009 Oper  input  NUM_OPERATIONS  opcode.
REQ-010 out_valid  output  1  result registers hold a valid result.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 Out  output  OPERAND_WIDTH  registered result.
REQ-013 Zero, Ofl, Cout, signFlag, err  output  1 each  registered flags.

Function
REQ-014 Operands SHALL be captured on an accept edge (in_valid & in_ready), with A = invA ? ~InA : InA and B = invB ? ~InB : InB.
REQ-015 Opcodes SHALL be: 0000 rotate left; 0001 shift left logical; 0010 shift right arithmetic; 0011 shift right logical; 0100 add; 0101 AND; 0110 OR; 0111 XOR; 1000 A << (OPERAND_WIDTH/2); 1001 bit-reverse A; 1010 rotate right; 1011 multiply; 11xx illegal.
REQ-016 Shift and rotate amount SHALL be B[log2(OPERAND_WIDTH)-1:0].
REQ-017 Add SHALL compute A+B+Cin.
  - Cout = carry out of the MSB.
  - Ofl = signed overflow when sign=1, otherwise Cout.
  - For all other opcodes except multiply, Ofl and Cout SHALL be 0.
REQ-018 Zero SHALL be (Out==0) and signFlag SHALL be Out[MSB], both derived from the registered result.
REQ-019 The state machine SHALL have states IDLE, MUL and DONE.
REQ-020 Single-cycle opcodes:
  - An accept in IDLE SHALL load the result on that edge and assert out_valid.
  - Latency SHALL be 1 cycle.
REQ-021 in_ready SHALL equal (state==IDLE) & (!out_valid | out_ready), giving back-to-back throughput of 1 op/cycle.
REQ-022 Multiply:
  - An accept SHALL enter MUL and run a shift-add iteration counter for OPERAND_WIDTH cycles.
  - On the last iteration edge the block SHALL go to DONE/IDLE with out_valid=1.
  - Accept-to-out_valid SHALL be OPERAND_WIDTH+1 edges.
  - in_ready SHALL be 0 throughout MUL.
REQ-023 Multiply results:
  - sign=0: Out = low half of the unsigned product; Ofl = (high half != 0).
  - sign=1: two's-complement product via magnitude and negate; Ofl = (high half != sign extension of Out[MSB]).
  - Cout SHALL be 0.
REQ-024 out_valid & !out_ready SHALL hold Out and all flags stable with no new accept; out_valid SHALL clear on an out_ready edge that has no simultaneous accept.
REQ-025 A simultaneous result drain and new accept SHALL replace the result registers in the same edge.
REQ-026 An illegal opcode SHALL produce Out=0 and err=1 with 1-cycle latency; err SHALL be 0 for legal opcodes.
REQ-027 Changes to InA, InB or Oper during MUL SHALL NOT affect the result.

Reset
REQ-028 rst SHALL asynchronously force:
  - state=IDLE, iteration counter=0;
  - out_valid=0, Out=0, and all flags 0.
REQ-029 Reset mid-multiply SHALL abort the multiply with no later out_valid; in_ready SHALL be 1 on the first edge after rst deasserts.

Configuration
REQ-030 Macro ALU_PIPE_MUL_EN:
  - Defined: multiply logic SHALL be present and opcode 1011 SHALL behave per REQ-022/023.
  - Undefined: MUL state and multiplier logic SHALL be absent, and 1011 SHALL be treated as illegal per REQ-026.

Verification
REQ-031 ADD, sign=1: A=0x7FFF, B=0x0001, Cin=0 -> next edge: Out=0x8000, Ofl=1, signFlag=1, Zero=0, out_valid=1.
REQ-032 MUL, sign=0: 0x0003 * 0x0005 -> in_ready=0 for 16 cycles; out_valid on edge 17 with Out=0x000F, Ofl=0.
REQ-033 MUL, sign=1: 0xFFFE * 0x0003 -> Out=0xFFFA, Ofl=0; and 0x0100 * 0x0100 -> Out=0x0000, Zero=1, Ofl=1.
REQ-034 Back-pressure: XOR result with out_ready=0 for 3 cycles -> Out stable, in_ready=0, second op not taken; raise out_ready -> second op accepted on the same edge.
REQ-035 rst pulsed at iteration 5 of a MUL -> out_valid=0 and Out=0 immediately; no result appears afterward; in_ready=1 after release.
REQ-036 Macro undefined: Oper=1011 -> next edge: Out=0, err=1, out_valid=1.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: ALU with registered result and flags behind a valid/ready handshake.
// Single-cycle opcodes load the result on the accept edge. Multiply runs as an
// iterative shift-add over OPERAND_WIDTH cycles.
// Optional feature: define ALU_PIPE_MUL_EN to build the multiplier (opcode 1011).
// Without it, 1011 is decoded as an illegal opcode.
module alu_pipe #(
  parameter int unsigned OPERAND_WIDTH  = 16,
  parameter int unsigned NUM_OPERATIONS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OPERAND_WIDTH-1:0]  InA,
  input  logic [OPERAND_WIDTH-1:0]  InB,
  input  logic                      Cin,
  input  logic                      invA,
  input  logic                      invB,
  input  logic                      sign,
  input  logic [NUM_OPERATIONS-1:0] Oper,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OPERAND_WIDTH-1:0]  Out,
  output logic                      Zero,
  output logic                      Ofl,
  output logic                      Cout,
  output logic                      signFlag,
  output logic                      err
);

  localparam int unsigned W  = OPERAND_WIDTH;
  localparam int unsigned SW = $clog2(OPERAND_WIDTH);

  localparam logic [NUM_OPERATIONS-1:0] OP_ROL = NUM_OPERATIONS'(0);
  localparam logic [NUM_OPERATIONS-1:0] OP_SLL = NUM_OPERATIONS'(1);
  localparam logic [NUM_OPERATIONS-1:0] OP_SRA = NUM_OPERATIONS'(2);
  localparam logic [NUM_OPERATIONS-1:0] OP_SRL = NUM_OPERATIONS'(3);
  localparam logic [NUM_OPERATIONS-1:0] OP_ADD = NUM_OPERATIONS'(4);
  localparam logic [NUM_OPERATIONS-1:0] OP_AND = NUM_OPERATIONS'(5);
  localparam logic [NUM_OPERATIONS-1:0] OP_OR  = NUM_OPERATIONS'(6);
  localparam logic [NUM_OPERATIONS-1:0] OP_XOR = NUM_OPERATIONS'(7);
  localparam logic [NUM_OPERATIONS-1:0] OP_SHH = NUM_OPERATIONS'(8);
  localparam logic [NUM_OPERATIONS-1:0] OP_REV = NUM_OPERATIONS'(9);
  localparam logic [NUM_OPERATIONS-1:0] OP_ROR = NUM_OPERATIONS'(10);
`ifdef ALU_PIPE_MUL_EN
  localparam logic [NUM_OPERATIONS-1:0] OP_MUL = NUM_OPERATIONS'(11);
`endif

  // DONE is never the landing state of a multiply: the completion edge goes
  // straight to IDLE so the result can drain alongside a new accept. A stray
  // DONE recovers to IDLE on the next edge.
`ifdef ALU_PIPE_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;
  localparam logic [W-1:0]    ONE_W   = W'(1);
  localparam logic [2*W-1:0]  ONE_2W  = (2*W)'(1);
  localparam logic [SW-1:0]   CNT_ONE = SW'(1);
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

  state_t         state_q, state_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_q, out_d;
  logic           zero_q, zero_d;
  logic           ofl_q, ofl_d;
  logic           cout_q, cout_d;
  logic           sign_q, sign_d;
  logic           err_q, err_d;

  logic [W-1:0]   a, b;
  logic [SW-1:0]  amt;
  logic [W:0]     sum;
  logic [2*W-1:0] rot_l, rot_r;
  logic [W-1:0]   rev;
  logic [W-1:0]   alu_res;
  logic           alu_ofl, alu_cout, alu_err;
  logic           accept;
  logic           load;
  logic [W-1:0]   load_res;
  logic           load_ofl, load_cout, load_err;

`ifdef ALU_PIPE_MUL_EN
  logic           op_is_mul;
  logic [SW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic           mul_neg_q, mul_neg_d;
  logic           mul_sgn_q, mul_sgn_d;
  logic [W-1:0]   mag_a, mag_b;
  logic [2*W-1:0] acc_sum, prod;
`endif

  // Operand conditioning: optional inversion and the shift/rotate amount
  always_comb begin
    a   = invA ? ~InA : InA;
    b   = invB ? ~InB : InB;
    amt = b[SW-1:0];
  end

  // Single-cycle opcode datapath evaluated on the presented operands
  always_comb begin
    alu_res  = '0;
    alu_ofl  = 1'b0;
    alu_cout = 1'b0;
    alu_err  = 1'b0;
    rev      = '0;
`ifdef ALU_PIPE_MUL_EN
    op_is_mul = 1'b0;
`endif
    sum   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, Cin};
    rot_l = {a, a} << amt;
    rot_r = {a, a} >> amt;
    for (int unsigned i = 0; i < W; i++) begin
      rev[i] = a[W-1-i];
    end
    case (Oper)
      OP_ROL: alu_res = rot_l[2*W-1:W];
      OP_SLL: alu_res = a << amt;
      OP_SRA: alu_res = $signed(a) >>> amt;
      OP_SRL: alu_res = a >> amt;
      OP_ADD: begin
        alu_res  = sum[W-1:0];
        alu_cout = sum[W];
        alu_ofl  = sign ? ((a[W-1] == b[W-1]) && (sum[W-1] != a[W-1])) : sum[W];
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SHH: alu_res = a << (W / 2);
      OP_REV: alu_res = rev;
      OP_ROR: alu_res = rot_r[W-1:0];
`ifdef ALU_PIPE_MUL_EN
      OP_MUL: op_is_mul = 1'b1;
`endif
      default: alu_err = 1'b1;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  // Multiplier support: operand magnitudes, one shift-add step, final sign fix-up
  always_comb begin
    mag_a   = (sign && a[W-1]) ? (~a + ONE_W) : a;
    mag_b   = (sign && b[W-1]) ? (~b + ONE_W) : b;
    acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    prod    = mul_neg_q ? (~acc_sum + ONE_2W) : acc_sum;
  end
`endif

  // Control FSM plus result-register next-state
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    zero_d      = zero_q;
    ofl_d       = ofl_q;
    cout_d      = cout_q;
    sign_d      = sign_q;
    err_d       = err_q;
    load        = 1'b0;
    load_res    = '0;
    load_ofl    = 1'b0;
    load_cout   = 1'b0;
    load_err    = 1'b0;
`ifdef ALU_PIPE_MUL_EN
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    mul_neg_d = mul_neg_q;
    mul_sgn_d = mul_sgn_q;
`endif

    in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    accept   = in_valid && in_ready;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef ALU_PIPE_MUL_EN
          if (op_is_mul) begin
            state_d   = MUL;
            cnt_d     = '0;
            acc_d     = '0;
            mcand_d   = {{W{1'b0}}, mag_a};
            mplier_d  = mag_b;
            mul_neg_d = sign && (a[W-1] ^ b[W-1]);
            mul_sgn_d = sign;
          end else
`endif
          begin
            load      = 1'b1;
            load_res  = alu_res;
            load_ofl  = alu_ofl;
            load_cout = alu_cout;
            load_err  = alu_err;
          end
        end
      end
`ifdef ALU_PIPE_MUL_EN
      MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == '1) begin
          state_d  = IDLE;
          cnt_d    = '0;
          load     = 1'b1;
          load_res = prod[W-1:0];
          load_ofl = mul_sgn_q ? (prod[2*W-1:W] != {W{prod[W-1]}})
                               : (prod[2*W-1:W] != '0);
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (load) begin
      out_valid_d = 1'b1;
      out_d       = load_res;
      zero_d      = (load_res == '0);
      sign_d      = load_res[W-1];
      ofl_d       = load_ofl;
      cout_d      = load_cout;
      err_d       = load_err;
    end
  end

  // State and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      zero_q      <= 1'b0;
      ofl_q       <= 1'b0;
      cout_q      <= 1'b0;
      sign_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      mul_neg_q   <= 1'b0;
      mul_sgn_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      zero_q      <= zero_d;
      ofl_q       <= ofl_d;
      cout_q      <= cout_d;
      sign_q      <= sign_d;
      err_q       <= err_d;
`ifdef ALU_PIPE_MUL_EN
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      mul_neg_q   <= mul_neg_d;
      mul_sgn_q   <= mul_sgn_d;
`endif
    end
  end

  // Output mapping
  always_comb begin
    out_valid = out_valid_q;
    Out       = out_q;
    Zero      = zero_q;
    Ofl       = ofl_q;
    Cout      = cout_q;
    signFlag  = sign_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe (16-bit operands, 4-bit opcode).
// Builds with or without ALU_PIPE_MUL_EN.
module tb_alu_pipe;

`ifdef ALU_PIPE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] InA, InB, Out;
  logic        Cin, invA, invB, sign;
  logic [3:0]  Oper;
  logic        out_valid, out_ready;
  logic        Zero, Ofl, Cout, signFlag, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_pipe #(.OPERAND_WIDTH(16), .NUM_OPERATIONS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .InA(InA), .InB(InB), .Cin(Cin), .invA(invA), .invB(invB), .sign(sign),
    .Oper(Oper), .out_valid(out_valid), .out_ready(out_ready), .Out(Out),
    .Zero(Zero), .Ofl(Ofl), .Cout(Cout), .signFlag(signFlag), .err(err)
  );

  // Reference model: returns {Out, Zero, Ofl, Cout, signFlag, err}
  function automatic logic [20:0] model(input logic [3:0] op, input logic [15:0] ina,
                                        input logic [15:0] inb, input logic cin,
                                        input logic inva, input logic invb, input logic sg);
    logic [15:0] a, b, rr;
    int ua, ub, sa, sb, n, s, r;
    longint p;
    logic o, c, e;
    a  = inva ? ~ina : ina;
    b  = invb ? ~inb : inb;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    n  = int'(b[3:0]);
    r = 0; o = 1'b0; c = 1'b0; e = 1'b0; p = 0;
    case (op)
      4'd0:  r = (ua << n) | (ua >> (16 - n));
      4'd1:  r = ua << n;
      4'd2:  r = sa >>> n;
      4'd3:  r = ua >> n;
      4'd4: begin
        s = ua + ub + int'(cin);
        r = s;
        c = (s > 65535);
        if (sg) begin
          s = sa + sb + int'(cin);
          o = (s > 32767) || (s < -32768);
        end else o = c;
      end
      4'd5:  r = ua & ub;
      4'd6:  r = ua | ub;
      4'd7:  r = ua ^ ub;
      4'd8:  r = ua * 256;
      4'd9:  for (int i = 0; i < 16; i++) if (a[i]) r = r + (1 << (15 - i));
      4'd10: r = (ua >> n) | (ua << (16 - n));
      4'd11: begin
        if (MUL_EN) begin
          if (sg) begin
            p = longint'(sa) * longint'(sb);
            o = (p > 32767) || (p < -32768);
          end else begin
            p = longint'(ua) * longint'(ub);
            o = (p > 65535);
          end
          r = int'(p & 64'hFFFF);
        end else e = 1'b1;
      end
      default: e = 1'b1;
    endcase
    rr = r[15:0];
    return {rr, (rr == 16'h0), o, c, rr[15], e};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] ina, input logic [15:0] inb,
                       input logic cin, input logic ia, input logic ib, input logic sg);
    Oper = op; InA = ina; InB = inb; Cin = cin; invA = ia; invB = ib; sign = sg;
  endtask

  task automatic drain;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(4'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) step;
    checks++;
    if ({out_valid, Out, Zero, Ofl, Cout, signFlag, err} !== 22'h0)
      $display("FAIL reset_outputs: got %h expected %h",
               {out_valid, Out, Zero, Ofl, Cout, signFlag, err}, 22'h0);
    #2 rst = 1'b0;
    step;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    if (in_ready !== 1'b1 || out_valid !== 1'b0) errors++;
  endtask

  // Random traffic with random in_valid/out_ready; the bench tracks validity itself
  task automatic test_back_to_back;
    logic [20:0] exp;
    logic        exp_ov, exp_rdy;
    logic [31:0] r1, r2, r3;
    logic [3:0]  op;
    exp = '0; exp_ov = 1'b0;
    for (int k = 0; k < 300; k++) begin
      r1 = $urandom; r2 = $urandom; r3 = $urandom;
      op = r3[3:0];
      if (MUL_EN && op == 4'd11) op = 4'd7;
      drive(op, r1[15:0], r2[15:0], r3[4], r3[5], r3[6], r3[7]);
      in_valid  = (r3[9:8] != 2'b00);
      out_ready = (r3[11:10] != 2'b00);
      #1;
      exp_rdy = !exp_ov || out_ready;
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL b2b_in_ready[%0d]: got %b expected %b", k, in_ready, exp_rdy);
      end
      if (in_valid && exp_rdy) begin
        exp    = model(op, r1[15:0], r2[15:0], r3[4], r3[5], r3[6], r3[7]);
        exp_ov = 1'b1;
      end else if (out_ready) exp_ov = 1'b0;
      step;
      checks++;
      if ({out_valid, Out, Zero, Ofl, Cout, signFlag, err} !== {exp_ov, exp}) begin
        errors++;
        $display("FAIL b2b_result[%0d] op=%0d: got %h expected %h", k, op,
                 {out_valid, Out, Zero, Ofl, Cout, signFlag, err}, {exp_ov, exp});
      end
    end
  endtask

  task automatic test_add;
    drain;
    drive(4'd4, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b1;
    step;
    checks++;
    if ({out_valid, Out, Zero, Ofl, Cout, signFlag, err} !== {1'b1, 16'h8000, 5'b01010}) begin
      errors++;
      $display("FAIL add_signed_ofl: got %h expected %h",
               {out_valid, Out, Zero, Ofl, Cout, signFlag, err}, {1'b1, 16'h8000, 5'b01010});
    end
    // Back-to-back: InA=0 inverted gives FFFF, +0 +Cin wraps to zero with carry
    drive(4'd4, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL add_b2b_ready: got %b expected 1", in_ready);
    end
    step;
    checks++;
    if ({out_valid, Out, Zero, Ofl, Cout, signFlag, err} !== {1'b1, 16'h0000, 5'b11100}) begin
      errors++;
      $display("FAIL add_unsigned_carry: got %h expected %h",
               {out_valid, Out, Zero, Ofl, Cout, signFlag, err}, {1'b1, 16'h0000, 5'b11100});
    end
    drive(4'd12, 16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0, 1'b0);
    step;
    checks++;
    if ({out_valid, Out, Zero, Ofl, Cout, signFlag, err} !== {1'b1, 16'h0000, 5'b10001}) begin
      errors++;
      $display("FAIL illegal_op: got %h expected %h",
               {out_valid, Out, Zero, Ofl, Cout, signFlag, err}, {1'b1, 16'h0000, 5'b10001});
    end
    in_valid = 1'b0;
    step;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_clears_valid: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_backpressure;
    logic [20:0] e1, e2;
    e1 = model(4'd7, 16'hA5F0, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0);
    e2 = model(4'd4, 16'h1111, 16'h2222, 1'b1, 1'b0, 1'b0, 1'b0);
    drain;
    drive(4'd7, 16'hA5F0, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1; out_ready = 1'b0;
    step;
    checks++;
    if ({out_valid, Out, Zero, Ofl, Cout, signFlag, err} !== {1'b1, e1}) begin
      errors++;
      $display("FAIL bp_first: got %h expected %h",
               {out_valid, Out, Zero, Ofl, Cout, signFlag, err}, {1'b1, e1});
    end
    drive(4'd4, 16'h1111, 16'h2222, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_in_ready[%0d]: got %b expected 0", k, in_ready);
      end
      step;
      checks++;
      if ({out_valid, Out, Zero, Ofl, Cout, signFlag, err} !== {1'b1, e1}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got %h expected %h", k,
                 {out_valid, Out, Zero, Ofl, Cout, signFlag, err}, {1'b1, e1});
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: got %b expected 1", in_ready);
    end
    step;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, Out, Zero, Ofl, Cout, signFlag, err} !== {1'b1, e2}) begin
      errors++;
      $display("FAIL bp_second: got %h expected %h",
               {out_valid, Out, Zero, Ofl, Cout, signFlag, err}, {1'b1, e2});
    end
  endtask

`ifdef ALU_PIPE_MUL_EN
  task automatic run_mul(input logic [15:0] ma, input logic [15:0] mb, input logic sg,
                         input logic [20:0] exp);
    logic [31:0] r;
    drain;
    drive(4'd11, ma, mb, 1'b0, 1'b0, 1'b0, sg);
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mul_start_ready: got %b expected 1", in_ready);
    end
    step;
    for (int k = 0; k < 16; k++) begin
      r = $urandom;
      drive(r[3:0], r[31:16], r[15:0], r[4], r[5], r[6], r[7]);
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mul_busy[%0d]: in_ready=%b out_valid=%b expected 0 0", k, in_ready, out_valid);
      end
      step;
    end
    in_valid = 1'b0;
    checks++;
    if ({out_valid, Out, Zero, Ofl, Cout, signFlag, err} !== {1'b1, exp}) begin
      errors++;
      $display("FAIL mul_result %h*%h s=%b: got %h expected %h", ma, mb, sg,
               {out_valid, Out, Zero, Ofl, Cout, signFlag, err}, {1'b1, exp});
    end
  endtask

  task automatic test_mul;
    logic [31:0] r;
    run_mul(16'h0003, 16'h0005, 1'b0, {16'h000F, 5'b00000});
    run_mul(16'hFFFE, 16'h0003, 1'b1, {16'hFFFA, 5'b00010});
    run_mul(16'h0100, 16'h0100, 1'b1, {16'h0000, 5'b11000});
    run_mul(16'h8000, 16'h8000, 1'b1, model(4'd11, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1));
    run_mul(16'hFFFF, 16'hFFFF, 1'b0, model(4'd11, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 10; k++) begin
      r = $urandom;
      if (k < 5) r = r & 32'h00FF_00FF;
      run_mul(r[31:16], r[15:0], k[0],
              model(4'd11, r[31:16], r[15:0], 1'b0, 1'b0, 1'b0, k[0]));
    end
  endtask
`else
  task automatic test_mul_disabled;
    drain;
    drive(4'd11, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, Out, Zero, Ofl, Cout, signFlag, err} !== {1'b1, 16'h0000, 5'b10001}) begin
      errors++;
      $display("FAIL mul_disabled_illegal: got %h expected %h",
               {out_valid, Out, Zero, Ofl, Cout, signFlag, err}, {1'b1, 16'h0000, 5'b10001});
    end
  endtask
`endif

  task automatic test_reset_recovery;
    logic bad;
    logic [20:0] e;
    drain;
    drive(4'd4, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    step;
`ifdef ALU_PIPE_MUL_EN
    drive(4'd11, 16'h1234, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
    step;
    in_valid = 1'b0;
    repeat (5) step;
`else
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) step;
`endif
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, Out, Zero, Ofl, Cout, signFlag, err} !== 22'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got %h rdy=%b expected 0 rdy=1",
               {out_valid, Out, Zero, Ofl, Cout, signFlag, err}, in_ready);
    end
    out_ready = 1'b1;
    step;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_exit_ready: got %b expected 1", in_ready);
    end
    bad = 1'b0;
    for (int k = 0; k < 24; k++) begin
      step;
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL aborted_result: got out_valid=1 expected 0");
    end
    e = model(4'd9, 16'h8001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(4'd9, 16'h8001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, Out, Zero, Ofl, Cout, signFlag, err} !== {1'b1, e}) begin
      errors++;
      $display("FAIL post_reset_op: got %h expected %h",
               {out_valid, Out, Zero, Ofl, Cout, signFlag, err}, {1'b1, e});
    end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_add;
    test_backpressure;
`ifdef ALU_PIPE_MUL_EN
    test_mul;
`else
    test_mul_disabled;
`endif
    test_reset_recovery;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
